// File: rtl/m_cache_refill_if.sv
// Bus bundle for the cache refill engine: CPU miss/store side, memory
// request/response side and the cache line install port.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

interface m_cache_refill_if;
    // Request channel: o_mreq/o_maddr are held stable until the cycle in which
    // o_mreq && i_mack is sampled high; that edge transfers one request.
    // Response channel has no backpressure: every i_mvalid cycle is one word,
    // returned in request order.
    logic                   i_miss;
    logic [`ADDR_WIDTH-1:0] i_addr;
    logic                   i_we;
    logic [`ADDR_WIDTH-1:0] i_waddr;
    logic [31:0]            i_wdata;
    logic                   o_stall;
    logic                   o_mreq;
    logic [`ADDR_WIDTH-1:0] o_maddr;
    logic                   i_mack;
    logic                   i_mvalid;
    logic [31:0]            i_mdata;
    logic                   o_bwe;
    logic [`ADDR_WIDTH-1:0] o_baddr;
    logic [127:0]           o_bdata;
    logic                   o_err;

    modport slave (
        input  i_miss, i_addr, i_we, i_waddr, i_wdata, i_mack, i_mvalid, i_mdata,
        output o_stall, o_mreq, o_maddr, o_bwe, o_baddr, o_bdata, o_err
    );

    modport master (
        output i_miss, i_addr, i_we, i_waddr, i_wdata, i_mack, i_mvalid, i_mdata,
        input  o_stall, o_mreq, o_maddr, o_bwe, o_baddr, o_bdata, o_err
    );
endinterface

// File: rtl/m_cache_refill.sv
// Read-miss refill engine: fetches a 4-word block critical word first, merges
// concurrent write-through stores, and installs the full line in one cycle.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module m_cache_refill (
    input  logic               i_clk,
    input  logic               i_rst_n,
    m_cache_refill_if.slave    bus,
    output logic [1:0]         o_state
);
    localparam int AW = `ADDR_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FETCH   = 2'd1,
        S_INSTALL = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [AW-1:0]  blk_q, blk_d;
    logic [1:0]     w0_q, w0_d;
    logic [2:0]     req_cnt_q, req_cnt_d;
    logic [2:0]     rsp_cnt_q, rsp_cnt_d;
    logic [3:0]     mask_q, mask_d;
    logic [127:0]   line_q, line_d;
    logic           err_q, err_d;
    logic           stall_q, stall_d;

    logic           st_hit;
    logic [1:0]     st_idx;
    logic [1:0]     rsp_idx;
    logic           unused_ok;

    assign unused_ok = ^{bus.i_addr[1:0], bus.i_waddr[1:0]};

    always_comb begin
        state_d   = state_q;
        blk_d     = blk_q;
        w0_d      = w0_q;
        req_cnt_d = req_cnt_q;
        rsp_cnt_d = rsp_cnt_q;
        mask_d    = mask_q;
        line_d    = line_q;
        err_d     = err_q;

        bus.o_mreq  = 1'b0;
        bus.o_maddr = '0;
        bus.o_bwe   = 1'b0;
        bus.o_baddr = '0;
        bus.o_bdata = '0;

        st_hit  = bus.i_we && (bus.i_waddr[AW-1:4] == blk_q[AW-1:4]);
        st_idx  = bus.i_waddr[3:2];
        rsp_idx = w0_q + rsp_cnt_q[1:0];

        case (state_q)
            S_IDLE: begin
                if (bus.i_miss) begin
                    blk_d     = {bus.i_addr[AW-1:4], 4'b0000};
                    w0_d      = bus.i_addr[3:2];
                    req_cnt_d = '0;
                    rsp_cnt_d = '0;
                    mask_d    = '0;
                    line_d    = '0;
                    state_d   = S_FETCH;
                end
            end

            S_FETCH: begin
                bus.o_mreq       = !req_cnt_q[2];
                bus.o_maddr      = blk_q;
                bus.o_maddr[3:2] = w0_q + req_cnt_q[1:0];
                if (bus.o_mreq && bus.i_mack) begin
                    req_cnt_d = req_cnt_q + 3'd1;
                end

                if (bus.i_mvalid) begin
                    if (rsp_cnt_q == req_cnt_q) begin
                        err_d = 1'b1;
                    end else begin
                        if (!mask_q[rsp_idx]) begin
                            line_d[{rsp_idx, 5'b00000} +: 32] = bus.i_mdata;
                        end
                        rsp_cnt_d = rsp_cnt_q + 3'd1;
                        if (rsp_cnt_q == 3'd3) begin
                            state_d = S_INSTALL;
                        end
                    end
                end

                // Store data is newer than any memory word for the same slot.
                if (st_hit) begin
                    line_d[{st_idx, 5'b00000} +: 32] = bus.i_wdata;
                    mask_d[st_idx]                   = 1'b1;
                end
            end

            S_INSTALL: begin
                bus.o_bwe   = 1'b1;
                bus.o_baddr = blk_q;
                bus.o_bdata = line_q;
                if (st_hit) begin
                    bus.o_bdata[{st_idx, 5'b00000} +: 32] = bus.i_wdata;
                    line_d[{st_idx, 5'b00000} +: 32]      = bus.i_wdata;
                    mask_d[st_idx]                        = 1'b1;
                end
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase

        stall_d = (state_d != S_IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            blk_q     <= '0;
            w0_q      <= '0;
            req_cnt_q <= '0;
            rsp_cnt_q <= '0;
            mask_q    <= '0;
            line_q    <= '0;
            err_q     <= 1'b0;
            stall_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            blk_q     <= blk_d;
            w0_q      <= w0_d;
            req_cnt_q <= req_cnt_d;
            rsp_cnt_q <= rsp_cnt_d;
            mask_q    <= mask_d;
            line_q    <= line_d;
            err_q     <= err_d;
            stall_q   <= stall_d;
        end
    end

    assign bus.o_stall = stall_q;
    assign bus.o_err   = err_q;
    assign o_state     = state_q;
endmodule

// File: tb/tb_m_cache_refill.sv
// Directed bench for m_cache_refill: memory model, store driver and an
// install/request scoreboard fed by the stimulus tasks.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module tb_m_cache_refill;
    localparam int AW = `ADDR_WIDTH;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] dut_state;

    always #5 clk = ~clk;

    m_cache_refill_if bus ();

    m_cache_refill dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus),
        .o_state (dut_state)
    );

    int n_vec = 0;
    int n_bad = 0;

    logic [127:0]  exp_q[$];
    logic [AW-1:0] exp_baddr_q[$];
    logic [AW-1:0] exp_maddr_q[$];
    logic [AW-1:0] pend_q[$];

    int mem_mode   = 0;
    int ack_delay  = 0;
    int ack_wait   = 0;
    int resp_count = 0;
    bit ack_off    = 1'b0;
    bit inject     = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_data(input logic [AW-1:0] a);
        if (mem_mode == 0) return 32'(a);
        return 32'h1111_1111 * {30'b0, a[3:2]};
    endfunction

    // Memory model: 1-cycle response latency, programmable ack throttling.
    initial begin : mem_model
        logic [AW-1:0] a;
        bus.i_mack   = 1'b0;
        bus.i_mvalid = 1'b0;
        bus.i_mdata  = '0;
        forever begin
            @(negedge clk);
            bus.i_mvalid = 1'b0;
            bus.i_mdata  = '0;
            if (pend_q.size() > 0) begin
                a            = pend_q.pop_front();
                bus.i_mvalid = 1'b1;
                bus.i_mdata  = mem_data(a);
                resp_count++;
            end else if (inject) begin
                bus.i_mvalid = 1'b1;
                bus.i_mdata  = 32'h0BAD_0BAD;
                inject       = 1'b0;
            end
            bus.i_mack = 1'b0;
            if (bus.o_mreq) begin
                if (exp_maddr_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL maddr_unexpected: got request %h, expected none", bus.o_maddr);
                end else begin
                    check("maddr", 128'(bus.o_maddr), 128'(exp_maddr_q[0]));
                end
                if (!ack_off) begin
                    if (ack_wait < ack_delay) begin
                        ack_wait++;
                    end else begin
                        ack_wait   = 0;
                        bus.i_mack = 1'b1;
                        pend_q.push_back(bus.o_maddr);
                        if (exp_maddr_q.size() > 0) void'(exp_maddr_q.pop_front());
                    end
                end
            end
        end
    end

    // Install monitor: every o_bwe pulse must match the next expected line.
    initial begin : install_mon
        forever begin
            @(negedge clk);
            if (bus.o_bwe) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL install_unexpected: got install at %h, expected none", bus.o_baddr);
                end else begin
                    check("bdata", bus.o_bdata, exp_q.pop_front());
                    check("baddr", 128'(bus.o_baddr), 128'(exp_baddr_q.pop_front()));
                    check("rsp_before_install", 128'(resp_count), 128'(4));
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no finish, expected end before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic start_miss(input logic [AW-1:0] a,
                              input logic [AW-1:0] m0, input logic [AW-1:0] m1,
                              input logic [AW-1:0] m2, input logic [AW-1:0] m3,
                              input bit expect_install, input logic [AW-1:0] baddr,
                              input logic [127:0] line, input int delay);
        exp_maddr_q.push_back(m0);
        exp_maddr_q.push_back(m1);
        exp_maddr_q.push_back(m2);
        exp_maddr_q.push_back(m3);
        if (expect_install) begin
            exp_q.push_back(line);
            exp_baddr_q.push_back(baddr);
        end
        ack_delay  = delay;
        resp_count = 0;
        bus.i_miss = 1'b1;
        bus.i_addr = a;
    endtask

    task automatic wait_install(output int cyc, output logic stall1,
                                input bit st_en, input logic [AW-1:0] sa, input logic [31:0] sd);
        bit done = 1'b0;
        cyc    = 0;
        stall1 = 1'b0;
        while (!done && cyc < 300) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 1) stall1 = bus.o_stall;
            if (bus.o_bwe) done = 1'b1;
        end
        if (!done) begin
            n_vec++;
            n_bad++;
            $display("FAIL install_timeout: got no o_bwe in %0d cycles, expected install", cyc);
        end
        if (st_en) begin
            bus.i_we    = 1'b1;
            bus.i_waddr = sa;
            bus.i_wdata = sd;
        end
        @(posedge clk);
        #1;
        bus.i_we   = 1'b0;
        bus.i_miss = 1'b0;
    endtask

    task automatic store(input logic [AW-1:0] a, input logic [31:0] d);
        bus.i_we    = 1'b1;
        bus.i_waddr = a;
        bus.i_wdata = d;
        @(posedge clk);
        #1;
        bus.i_we = 1'b0;
    endtask

    initial begin : stim
        int   cyc;
        logic st1;
        int   guard;

        bus.i_miss  = 1'b0;
        bus.i_addr  = '0;
        bus.i_we    = 1'b0;
        bus.i_waddr = '0;
        bus.i_wdata = '0;
        rst_n       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_stall", 128'(bus.o_stall), 128'(0));
        check("rst_mreq",  128'(bus.o_mreq),  128'(0));
        check("rst_bwe",   128'(bus.o_bwe),   128'(0));
        check("rst_err",   128'(bus.o_err),   128'(0));
        check("rst_state", 128'(dut_state),   128'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Critical word first with wrap, fastest memory.
        mem_mode = 0;
        start_miss(32'h1238, 32'h1238, 32'h123C, 32'h1230, 32'h1234, 1'b1, 32'h1230,
                   {32'h123C, 32'h1238, 32'h1234, 32'h1230}, 0);
        wait_install(cyc, st1, 1'b0, '0, '0);
        check("t1_stall_rise", 128'(st1), 128'(1));
        check("t1_latency", 128'(cyc), 128'(6));
        check("t1_stall_fall", 128'(bus.o_stall), 128'(0));
        check("t1_err", 128'(bus.o_err), 128'(0));

        // Throttled acks: address must hold until accepted.
        start_miss(32'h40, 32'h40, 32'h44, 32'h48, 32'h4C, 1'b1, 32'h40,
                   {32'h4C, 32'h48, 32'h44, 32'h40}, 3);
        wait_install(cyc, st1, 1'b0, '0, '0);
        check("t2_latency", 128'(cyc), 128'(18));

        // Store merge during fetch; other-block store ignored.
        mem_mode = 1;
        start_miss(32'h80, 32'h80, 32'h84, 32'h88, 32'h8C, 1'b1, 32'h80,
                   {32'h3333_3333, 32'h2222_2222, 32'hDEAD_BEEF, 32'h0000_0000}, 2);
        @(posedge clk);
        #1;
        store(32'h84, 32'hDEAD_BEEF);
        store(32'h94, 32'h5555_5555);
        wait_install(cyc, st1, 1'b0, '0, '0);

        // Store in the install cycle appears in the same cycle.
        start_miss(32'h80, 32'h80, 32'h84, 32'h88, 32'h8C, 1'b1, 32'h80,
                   {32'hCAFE_F00D, 32'h2222_2222, 32'h1111_1111, 32'h0000_0000}, 0);
        wait_install(cyc, st1, 1'b1, 32'h8C, 32'hCAFE_F00D);

        // Reset mid-refill: no install, late responses dropped silently.
        mem_mode = 0;
        start_miss(32'hC0, 32'hC0, 32'hC4, 32'hC8, 32'hCC, 1'b0, '0, '0, 0);
        guard = 0;
        while (resp_count < 2 && guard < 50) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("t5_two_rsp", 128'(resp_count >= 2), 128'(1));
        rst_n      = 1'b0;
        bus.i_miss = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_maddr_q.delete();
        check("t5_stall_after_rst", 128'(bus.o_stall), 128'(0));
        check("t5_state_after_rst", 128'(dut_state), 128'(0));
        repeat (5) @(posedge clk);
        #1;
        check("t5_err_late_rsp", 128'(bus.o_err), 128'(0));
        check("t5_stall_idle", 128'(bus.o_stall), 128'(0));
        start_miss(32'h100, 32'h100, 32'h104, 32'h108, 32'h10C, 1'b1, 32'h100,
                   {32'h10C, 32'h108, 32'h104, 32'h100}, 0);
        wait_install(cyc, st1, 1'b0, '0, '0);
        check("t5_latency", 128'(cyc), 128'(6));

        // Spurious response: sticky error, line unaffected.
        ack_off = 1'b1;
        start_miss(32'h140, 32'h140, 32'h144, 32'h148, 32'h14C, 1'b1, 32'h140,
                   {32'h14C, 32'h148, 32'h144, 32'h140}, 0);
        @(posedge clk);
        #1;
        check("t6_err_before", 128'(bus.o_err), 128'(0));
        inject = 1'b1;
        @(posedge clk);
        #1;
        check("t6_err_set", 128'(bus.o_err), 128'(1));
        ack_off = 1'b0;
        wait_install(cyc, st1, 1'b0, '0, '0);
        check("t6_err_sticky", 128'(bus.o_err), 128'(1));
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("t6_err_cleared", 128'(bus.o_err), 128'(0));

        repeat (4) @(posedge clk);
        #1;
        check("installs_pending", 128'(exp_q.size()), 128'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
